// File: rtl/i2c_seq_config.sv
// i2c_seq_config: walks a {sub_addr, data} table held in a synchronous ROM and
// issues one I2C write per entry to a fixed slave via the i2c master handshake.
// Handshake with the master: i2c_start is a level held from START until the
// master drops i2c_end (busy). The transfer result (i2c_ack) is taken on the
// first cycle i2c_end returns high. A transfer already on the bus always runs
// to completion, even when a restart has been requested.
module i2c_seq_config #(
   parameter logic [7:0]  SLAVE_ADDR = 8'h72,
   parameter int          DEPTH      = 128,
   localparam int         IW         = $clog2(DEPTH),
   parameter logic [15:0] TERM       = 16'hFFFF,
   parameter int          MAX_RETRY  = 3,
   parameter int          GAP_CYCLES = 16
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          reconfig,
   output logic [IW-1:0] tbl_addr,
   input  logic [15:0]   tbl_data,
   output logic [23:0]   i2c_data,
   output logic          i2c_start,
   input  logic          i2c_end,
   input  logic          i2c_ack,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [IW-1:0] err_index,
   output logic [7:0]    retries
);

   // Index carries one extra bit so that "one past the last entry" is
   // representable and can be treated as an implicit terminator.
   localparam int                XW       = IW + 1;
   localparam logic [XW-1:0]     DEPTH_X  = XW'(DEPTH);
   localparam int                GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0]     GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [7:0]        MAX_R    = 8'(MAX_RETRY);

   // FETCH drives the ROM address, FETCH_W covers the ROM read latency.
   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_FETCH_W = 4'd1,
      S_CHECK   = 4'd2,
      S_START   = 4'd3,
      S_WBUSY   = 4'd4,
      S_WEND    = 4'd5,
      S_GAP     = 4'd6,
      S_DONE    = 4'd7,
      S_FAIL    = 4'd8
   } state_e;

   state_e          state_q, state_d;
   logic [XW-1:0]   index_q, index_d;
   logic [7:0]      rcnt_q, rcnt_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic            retry_pend_q, retry_pend_d;
   logic            pend_q, pend_d;
   logic [IW-1:0]   tbl_addr_q, tbl_addr_d;
   logic [23:0]     i2c_data_q, i2c_data_d;
   logic            i2c_start_q, i2c_start_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [IW-1:0]   err_index_q, err_index_d;
   logic [7:0]      retries_q, retries_d;
   logic            restart;
   logic            to_gap;

   // State and output registers; synchronous reset returns everything to the
   // idle values with the FSM parked in FETCH so a run begins on release.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q      <= S_FETCH;
         index_q      <= '0;
         rcnt_q       <= '0;
         gap_q        <= '0;
         retry_pend_q <= 1'b0;
         pend_q       <= 1'b0;
         tbl_addr_q   <= '0;
         i2c_data_q   <= '0;
         i2c_start_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_index_q  <= '0;
         retries_q    <= '0;
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         rcnt_q       <= rcnt_d;
         gap_q        <= gap_d;
         retry_pend_q <= retry_pend_d;
         pend_q       <= pend_d;
         tbl_addr_q   <= tbl_addr_d;
         i2c_data_q   <= i2c_data_d;
         i2c_start_q  <= i2c_start_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         err_index_q  <= err_index_d;
         retries_q    <= retries_d;
      end
   end

   // Next-state logic: table walk, retry bookkeeping, error capture and
   // restart handling (immediate outside a transfer, deferred inside one).
   always_comb begin
      state_d      = state_q;
      index_d      = index_q;
      rcnt_d       = rcnt_q;
      gap_d        = gap_q;
      retry_pend_d = retry_pend_q;
      pend_d       = pend_q;
      i2c_data_d   = i2c_data_q;
      err_d        = err_q;
      err_index_d  = err_index_q;
      retries_d    = retries_q;
      restart      = 1'b0;
      to_gap       = 1'b0;

      case (state_q)
         S_FETCH: begin
            state_d = S_FETCH_W;
            if (reconfig) restart = 1'b1;
         end
         S_FETCH_W: begin
            state_d = S_CHECK;
            if (reconfig) restart = 1'b1;
         end
         S_CHECK: begin
            if ((tbl_data == TERM) || (index_q == DEPTH_X)) begin
               state_d = S_DONE;
               err_d   = 1'b0;
            end else begin
               i2c_data_d = {SLAVE_ADDR, tbl_data};
               rcnt_d     = '0;
               state_d    = S_START;
            end
            if (reconfig) restart = 1'b1;
         end
         S_START: begin
            state_d = S_WBUSY;
            if (reconfig) pend_d = 1'b1;
         end
         S_WBUSY: begin
            if (!i2c_end) state_d = S_WEND;
            if (reconfig) pend_d = 1'b1;
         end
         S_WEND: begin
            if (i2c_end) begin
               if (pend_q || reconfig) begin
                  // Result of the aborted transfer is discarded.
                  restart = 1'b1;
               end else if (!i2c_ack) begin
                  index_d      = index_q + XW'(1);
                  retry_pend_d = 1'b0;
                  to_gap       = 1'b1;
               end else if (rcnt_q < MAX_R) begin
                  rcnt_d       = rcnt_q + 8'd1;
                  retries_d    = (retries_q == 8'hFF) ? retries_q : retries_q + 8'd1;
                  retry_pend_d = 1'b1;
                  to_gap       = 1'b1;
               end else begin
                  err_d       = 1'b1;
                  err_index_d = index_q[IW-1:0];
                  state_d     = S_FAIL;
               end
            end else if (reconfig) begin
               pend_d = 1'b1;
            end
         end
         S_GAP: begin
            if (reconfig) begin
               restart = 1'b1;
            end else if (gap_q == '0) begin
               state_d = retry_pend_q ? S_START : S_FETCH;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         S_DONE, S_FAIL: begin
            if (reconfig) restart = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase

      // A zero-length gap goes straight to the follow-on state.
      if (to_gap) begin
         if (GAP_CYCLES == 0) begin
            state_d = retry_pend_d ? S_START : S_FETCH;
         end else begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
         end
      end

      // Restart keeps err/err_index; only a later completed run clears err.
      if (restart) begin
         state_d      = S_FETCH;
         index_d      = '0;
         rcnt_d       = '0;
         retries_d    = '0;
         pend_d       = 1'b0;
         retry_pend_d = 1'b0;
      end
   end

   // Registered outputs derived from the state being entered.
   always_comb begin
      tbl_addr_d  = tbl_addr_q;
      if (state_q == S_FETCH) tbl_addr_d = index_q[IW-1:0];
      i2c_start_d = (state_d == S_START) || (state_d == S_WBUSY);
      busy_d      = !((state_d == S_DONE) || (state_d == S_FAIL));
      done_d      = (state_d == S_DONE);
   end

   assign tbl_addr  = tbl_addr_q;
   assign i2c_data  = i2c_data_q;
   assign i2c_start = i2c_start_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_index = err_index_q;
   assign retries   = retries_q;

endmodule

// File: tb/tb_i2c_seq_config.sv
// Bench for i2c_seq_config: synchronous ROM model, behavioural I2C master with
// a scripted ACK/NACK queue, and a transaction-level reference model.
module tb_i2c_seq_config;

   localparam int          DEPTH = 4;
   localparam int          IW    = 2;
   localparam logic [15:0] TERM  = 16'hFFFF;
   localparam int          MAXR  = 3;
   localparam logic [7:0]  SLAVE = 8'h72;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          iRST;
   logic          reconfig;
   logic [IW-1:0] tbl_addr;
   logic [15:0]   tbl_data;
   logic [23:0]   i2c_data;
   logic          i2c_start;
   logic          i2c_end;
   logic          i2c_ack;
   logic          busy;
   logic          done;
   logic          err;
   logic [IW-1:0] err_index;
   logic [7:0]    retries;

   i2c_seq_config #(
      .SLAVE_ADDR (SLAVE),
      .DEPTH      (DEPTH),
      .TERM       (TERM),
      .MAX_RETRY  (MAXR),
      .GAP_CYCLES (4)
   ) dut (
      .iCLK      (clk),
      .iRST      (iRST),
      .reconfig  (reconfig),
      .tbl_addr  (tbl_addr),
      .tbl_data  (tbl_data),
      .i2c_data  (i2c_data),
      .i2c_start (i2c_start),
      .i2c_end   (i2c_end),
      .i2c_ack   (i2c_ack),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_index (err_index),
      .retries   (retries)
   );

   // ---------------- ROM model (1-cycle latency) ----------------
   logic [15:0] rom [DEPTH];
   always @(posedge clk) tbl_data <= rom[tbl_addr];

   // ---------------- scoreboard state ----------------
   logic [23:0] exp_q[$];
   logic [23:0] obs_q[$];
   bit          ack_q[$];
   bit          script[$];
   int          vec_cnt = 0;
   int          err_cnt = 0;
   bit          m_err = 1'b0;
   logic [IW-1:0] m_eidx = '0;
   bit          exp_done;
   int          exp_retries;

   // ---------------- I2C master model ----------------
   int  ms_state;
   int  ms_dly;
   int  ms_len;
   bit  ms_ack;
   initial begin
      i2c_end  = 1'b1;
      i2c_ack  = 1'b0;
      ms_state = 0;
      forever begin
         @(posedge clk);
         #1;
         if (iRST) begin
            ms_state = 0;
            i2c_end  = 1'b1;
            i2c_ack  = 1'b0;
         end else begin
            case (ms_state)
               0: if (i2c_start) begin
                  obs_q.push_back(i2c_data);
                  ms_ack   = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
                  ms_dly   = $urandom_range(0, 2);
                  ms_state = 1;
               end
               1: if (ms_dly == 0) begin
                  i2c_end  = 1'b0;
                  ms_len   = $urandom_range(1, 5);
                  ms_state = 2;
               end else begin
                  ms_dly--;
               end
               default: if (ms_len == 0) begin
                  i2c_end  = 1'b1;
                  i2c_ack  = ms_ack;
                  ms_state = 0;
               end else begin
                  ms_len--;
               end
            endcase
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: expected write list and end status from table + script.
   task automatic model_run();
      int idx;
      int t;
      int att;
      int rtr;
      bit fin;
      bit nack;
      idx = 0; t = 0; rtr = 0; fin = 1'b0;
      exp_q.delete();
      exp_done = 1'b0;
      while (!fin) begin
         if (idx == DEPTH || rom[idx] == TERM) begin
            exp_done = 1'b1;
            m_err    = 1'b0;
            fin      = 1'b1;
         end else begin
            att = 0;
            forever begin
               exp_q.push_back({SLAVE, rom[idx]});
               nack = (t < script.size()) ? script[t] : 1'b0;
               t++;
               if (!nack) begin
                  idx++;
                  break;
               end
               if (att < MAXR) begin
                  att++;
                  if (rtr < 255) rtr++;
               end else begin
                  m_err    = 1'b1;
                  m_eidx   = idx[IW-1:0];
                  exp_done = 1'b0;
                  fin      = 1'b1;
                  break;
               end
            end
         end
      end
      exp_retries = rtr;
   endtask

   task automatic check_run(input string tag);
      chk($sformatf("%s_nxfer", tag), obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk($sformatf("%s_xfer%0d", tag, i), obs_q[i], exp_q[i]);
      chk($sformatf("%s_done", tag), done, exp_done);
      chk($sformatf("%s_busy", tag), busy, 0);
      chk($sformatf("%s_err", tag), err, m_err);
      chk($sformatf("%s_eidx", tag), err_index, m_eidx);
      chk($sformatf("%s_retries", tag), retries, exp_retries);
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_idle(input string tag);
      for (int i = 0; i < 4000; i++) begin
         if (!busy) break;
         @(posedge clk);
         #2;
      end
      chk($sformatf("%s_idle", tag), busy, 0);
   endtask

   task automatic pulse_reconfig();
      reconfig = 1'b1;
      @(posedge clk);
      #2;
      reconfig = 1'b0;
   endtask

   task automatic launch(input string tag);
      ack_q = script;
      obs_q.delete();
      pulse_reconfig();
      chk($sformatf("%s_busy_on", tag), busy, 1);
      model_run();
      wait_idle(tag);
      check_run(tag);
   endtask

   task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
      rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit found;
      iRST     = 1'b1;
      reconfig = 1'b0;
      load_rom(TERM, TERM, TERM, TERM);
      repeat (3) @(posedge clk);
      #2;
      chk("rst_tbl_addr", tbl_addr, 0);
      chk("rst_i2c_data", i2c_data, 0);
      chk("rst_start", i2c_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_eidx", err_index, 0);
      chk("rst_retries", retries, 0);

      // Empty table: busy in cycle 1, done in cycle 3.
      obs_q.delete();
      iRST = 1'b0;
      @(posedge clk); #2;
      chk("empty_busy_c1", busy, 1);
      chk("empty_done_c1", done, 0);
      @(posedge clk); #2;
      chk("empty_done_c2", done, 0);
      @(posedge clk); #2;
      chk("empty_done_c3", done, 1);
      script.delete();
      model_run();
      check_run("empty");

      // Basic two-entry table, all ACK.
      load_rom(16'h9803, 16'hD6C0, TERM, 16'h1234);
      script.delete();
      launch("basic");
      chk("basic_first", obs_q.size() > 0 ? obs_q[0] : 24'h0, 24'h729803);

      // Entry 1 NACKs twice then ACKs.
      script = '{1'b0, 1'b1, 1'b1, 1'b0};
      launch("retry2");

      // Entry 1 never ACKs: error, then a clean re-run clears err.
      script = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      launch("exhaust");
      script.delete();
      launch("recover");

      // Restart requested while entry 1 is on the bus (and it NACKs).
      script = '{1'b0, 1'b1};
      ack_q  = script;
      obs_q.delete();
      pulse_reconfig();
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (obs_q.size() == 2 && !i2c_start && !i2c_end) found = 1'b1;
         else begin
            @(posedge clk);
            #2;
         end
      end
      chk("abort_wend_seen", found, 1);
      pulse_reconfig();
      @(posedge clk); #2;
      pulse_reconfig();
      script.delete();
      model_run();
      exp_q.push_front({SLAVE, rom[1]});
      exp_q.push_front({SLAVE, rom[0]});
      wait_idle("abort");
      check_run("abort");

      // Full table without a terminator.
      load_rom(16'h0102, 16'h0304, 16'h0506, 16'h0708);
      script.delete();
      launch("full");

      // Randomized tables and ACK/NACK scripts.
      for (int r = 0; r < 12; r++) begin
         int p;
         for (int k = 0; k < DEPTH; k++) rom[k] = 16'($urandom_range(0, 16'hFFFE));
         p = $urandom_range(0, DEPTH);
         if (p < DEPTH) rom[p] = TERM;
         script.delete();
         for (int k = 0; k < 12; k++) script.push_back($urandom_range(0, 3) == 0);
         launch($sformatf("rnd%0d", r));
      end

      // Reset asserted while waiting for the master to go busy.
      load_rom(16'h9803, 16'hD6C0, TERM, 16'h1234);
      script = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      launch("pre_rst");
      script.delete();
      ack_q.delete();
      obs_q.delete();
      pulse_reconfig();
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (i2c_start) found = 1'b1;
         else begin
            @(posedge clk);
            #2;
         end
      end
      chk("rst_start_seen", found, 1);
      @(posedge clk); #2;
      iRST = 1'b1;
      @(posedge clk); #2;
      chk("mid_rst_tbl_addr", tbl_addr, 0);
      chk("mid_rst_i2c_data", i2c_data, 0);
      chk("mid_rst_start", i2c_start, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_eidx", err_index, 0);
      chk("mid_rst_retries", retries, 0);
      obs_q.delete();
      ack_q.delete();
      m_err  = 1'b0;
      m_eidx = '0;
      iRST   = 1'b0;
      @(posedge clk); #2;
      chk("post_rst_busy", busy, 1);
      model_run();
      wait_idle("post_rst");
      check_run("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
